ram_arbiter: RTL
================

# ram_arbiter

Two-requester arbiter and sequencer in front of the data RAM. It shares the single RAM port between the CPU memory stage (port 0) and the loader/DMA port (port 1) using round-robin selection. Each access runs through a fixed three-state sequence, and out-of-range or misaligned addresses are rejected with an error response. It sits between the MEM-stage/loader logic and the RAM instance, and drives the RAM's address, data_write, write_en and read_en inputs.

## Interface
- DATA_WIDTH, 32, RAM word width
- MEM_WORDS, 32, number of RAM words; valid byte addresses are 0 .. 4*MEM_WORDS-1
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- p0_req / p1_req  in  1  access request; held until the matching done
- p0_we / p1_we  in  1  1 = write, 0 = read; sampled with req
- p0_addr / p1_addr  in  32  byte address
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data
- p0_gnt / p1_gnt  out  1  one-cycle pulse: request accepted, RAM access in progress
- p0_done / p1_done  out  1  one-cycle pulse: access finished
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data, valid while done=1 and the access was a read
- p0_err / p1_err  out  1  valid with done; 1 = access rejected
- ram_address  out  32  byte address to RAM
- ram_data_write  out  DATA_WIDTH  write data to RAM
- ram_write_en  out  1  RAM write strobe
- ram_read_en  out  1  RAM read enable
- ram_data_out  in  DATA_WIDTH  combinational RAM read data
- busy  out  1  1 when state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If no request is present, stay in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port that is not last_grant wins.
  - The winner's id, we, addr and wdata are latched into cur_*, last_grant is set to the winner, and the FSM moves to ACCESS.
- **ACCESS (one cycle):**
  - The winner's gnt is 1.
  - Validity check: addr[1:0]==0 and addr[31:2] < MEM_WORDS.
  - Valid write: ram_write_en=1, ram_address=cur_addr, ram_data_write=cur_wdata.
  - Valid read: ram_read_en=1, and ram_data_out is captured into the winner's rdata register at the clock edge.
  - Invalid access: both RAM enables stay 0, the error flag is set, and rdata is set to 0.
  - The FSM moves to RESP.
- **RESP (one cycle):**
  - The winner's done is 1, and err is 1 if the access was rejected.
  - rdata holds the captured value.
  - The FSM moves to IDLE unconditionally.
- The RAM-side outputs are decoded from state==ACCESS and the cur_* registers.
  - Outside ACCESS: ram_write_en=0, ram_read_en=0, and ram_address and ram_data_write hold their last value.
- A req dropped after it has been latched does not cancel the access; it still completes.
- The losing port's request is neither latched nor acknowledged. It must stay asserted and is served next.
- A requester deasserts req in the cycle after it sees done; a req still high in IDLE is treated as a new request.
- Reset values:
  - state = IDLE, last_grant = 1 (port 0 wins the first tie).
  - All gnt, done, err, busy, ram_write_en and ram_read_en = 0.
  - ram_address = 0, ram_data_write = 0, both rdata = 0.
- Reset asserted mid-operation: the FSM returns to IDLE asynchronously, any pending write is not performed (write_en drops with state), and no done is issued.

## Timing
- A request sampled high in IDLE at edge N gives gnt high during cycle N..N+1 and done high during cycle N+1..N+2.
- Each access occupies 3 cycles including the IDLE cycle. Peak throughput is one access per 3 cycles.
- Read data is sampled from ram_data_out at the edge that ends ACCESS.
- gnt and done are mutually exclusive, and never high on both ports at once.
- Under sustained contention, each port waits at most one access (3 cycles) before being granted.
- On reset release, the first arbitration happens at the first rising edge with reset=1.

## Test plan
- **Reset:** hold reset=0 with random reqs → all outputs 0, busy=0; release with both req high → p0 is granted first.
- **Single read:** RAM word 3 = 12, p0 reads addr 0x0C → ram_read_en=1 for exactly 1 cycle, p0_done with p0_rdata=12, p0_err=0, total latency 3 cycles.
- **Write then read:** p1 writes 0xDEADBEEF to addr 0x10, then p0 reads 0x10 → ram_write_en=1 for one cycle with ram_address=0x10; the p0 read returns 0xDEADBEEF.
- **Contention:** both ports continuously request reads → grants alternate p0, p1, p0, p1; each done arrives on the correct port only; rdata matches the addressed word.
- **Errors:** p0 reads 0x80 (MEM_WORDS=32), then p1 writes 0x06 (misaligned) → no RAM enable asserted; done with err=1 and rdata=0; RAM contents unchanged.
- **Reset mid-access:** assert reset during the ACCESS cycle of a p1 write → ram_write_en drops immediately, the target word is not modified, no p1_done is issued, FSM is in IDLE.

Source files
------------

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter_if
// Brief   : requester-side and RAM-side signals of the data-RAM arbiter
// Revision: 1.0
// ============================================================================
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  p0_req;
    logic                  p0_we;
    logic [31:0]           p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_gnt;
    logic                  p0_done;
    logic                  p0_err;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [31:0]           p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_gnt;
    logic                  p1_done;
    logic                  p1_err;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic [31:0]           ram_address;
    logic [DATA_WIDTH-1:0] ram_data_write;
    logic                  ram_write_en;
    logic                  ram_read_en;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic                  busy;

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ram_data_out,
        output p0_gnt, p0_done, p0_err, p0_rdata,
        output p1_gnt, p1_done, p1_err, p1_rdata,
        output ram_address, ram_data_write, ram_write_en, ram_read_en, busy
    );

    // Requesters plus RAM model side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ram_data_out,
        input  p0_gnt, p0_done, p0_err, p0_rdata,
        input  p1_gnt, p1_done, p1_err, p1_rdata,
        input  ram_address, ram_data_write, ram_write_en, ram_read_en, busy
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Brief   : round-robin two-port arbiter and IDLE/ACCESS/RESP sequencer
//           in front of the single-port data RAM
// Revision: 1.0
// ============================================================================
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 32
) (
    input  wire logic    clk_i,
    input  wire logic    rst_ni,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [29:0] c_mem_words = 30'(MEM_WORDS);

    state_t                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  cur_id_q,     cur_id_d;
    logic                  cur_we_q,     cur_we_d;
    logic [31:0]           cur_addr_q,   cur_addr_d;
    logic [DATA_WIDTH-1:0] cur_wdata_q,  cur_wdata_d;
    logic                  err_q,        err_d;
    logic [DATA_WIDTH-1:0] rdata0_q,     rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q,     rdata1_d;
    logic [31:0]           ram_addr_q,   ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q,  ram_wdata_d;

    logic w_valid;
    logic w_access;
    logic w_winner;
    logic w_wr_en;
    logic w_rd_en;

    assign w_valid  = (cur_addr_q[1:0] == 2'b00) && (cur_addr_q[31:2] < c_mem_words);
    assign w_access = (state_q == S_ACCESS);
    // On a tie the port that did not win last time goes first.
    assign w_winner = (bus.p0_req && bus.p1_req) ? ~last_grant_q : bus.p1_req;
    assign w_wr_en  = w_access && w_valid &&  cur_we_q;
    assign w_rd_en  = w_access && w_valid && !cur_we_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            cur_we_q     <= 1'b0;
            cur_addr_q   <= '0;
            cur_wdata_q  <= '0;
            err_q        <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            cur_we_q     <= cur_we_d;
            cur_addr_q   <= cur_addr_d;
            cur_wdata_q  <= cur_wdata_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        cur_we_d     = cur_we_q;
        cur_addr_d   = cur_addr_q;
        cur_wdata_d  = cur_wdata_q;
        err_d        = err_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    cur_id_d     = w_winner;
                    cur_we_d     = w_winner ? bus.p1_we    : bus.p0_we;
                    cur_addr_d   = w_winner ? bus.p1_addr  : bus.p0_addr;
                    cur_wdata_d  = w_winner ? bus.p1_wdata : bus.p0_wdata;
                    last_grant_d = w_winner;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                err_d = ~w_valid;
                if (w_valid) begin
                    // Held copies keep the RAM address/data stable outside ACCESS.
                    ram_addr_d = cur_addr_q;
                    if (cur_we_q) begin
                        ram_wdata_d = cur_wdata_q;
                    end else if (cur_id_q) begin
                        rdata1_d = bus.ram_data_out;
                    end else begin
                        rdata0_d = bus.ram_data_out;
                    end
                end else if (cur_id_q) begin
                    rdata1_d = '0;
                end else begin
                    rdata0_d = '0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ram_write_en   = w_wr_en;
    assign bus.ram_read_en    = w_rd_en;
    assign bus.ram_address    = (w_access && w_valid) ? cur_addr_q : ram_addr_q;
    assign bus.ram_data_write = w_wr_en ? cur_wdata_q : ram_wdata_q;

    assign bus.p0_gnt   = w_access && !cur_id_q;
    assign bus.p1_gnt   = w_access &&  cur_id_q;
    assign bus.p0_done  = (state_q == S_RESP) && !cur_id_q;
    assign bus.p1_done  = (state_q == S_RESP) &&  cur_id_q;
    assign bus.p0_err   = bus.p0_done && err_q;
    assign bus.p1_err   = bus.p1_done && err_q;
    assign bus.p0_rdata = rdata0_q;
    assign bus.p1_rdata = rdata1_q;
    assign bus.busy     = (state_q != S_IDLE);
endmodule
`default_nettype wire
